// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
//   clk, rst_n                : clock (rising edge) and async active-low reset
//   in_valid/in_ready         : operand handshake; in_ready follows the global advance enable
//   in_a, in_b, in_cin, in_sub: operands, carry-in (add only), subtract select
//   out_valid/out_ready       : result handshake; outputs held stable while stalled
//   out_sum, out_cout         : result mod 2^WIDTH and carry-out (sub: 1 = no borrow)
//   out_ovf, out_zero         : signed overflow and zero flags
// Latency from accept to out_valid is 1 + ceil(clog2(WIDTH)/REG_EVERY) cycles.
module ks_adder_pipe #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned REG_EVERY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int unsigned LEVELS = $clog2(WIDTH);
   localparam int unsigned NSTG   = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam int unsigned LAST   = NSTG - 1;

   // Group generate after REG_EVERY prefix levels starting at level 'first'.
   // P is tracked locally because later levels in the group need it.
   function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g_in,
                                             input logic [WIDTH-1:0] p_in,
                                             input int unsigned      first);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      int unsigned      span;
      g = g_in;
      p = p_in;
      for (int unsigned j = 0; j < REG_EVERY; j++) begin
         if (first + j < LEVELS) begin
            span = 32'd1 << (first + j);
            g    = g | (p & (g << span));
            p    = p & ((p << span) | ~({WIDTH{1'b1}} << span));
         end
      end
      return g;
   endfunction

   // Group propagate after the same levels; low 'span' bits pass through.
   function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p_in,
                                             input int unsigned      first);
      logic [WIDTH-1:0] p;
      int unsigned      span;
      p = p_in;
      for (int unsigned j = 0; j < REG_EVERY; j++) begin
         if (first + j < LEVELS) begin
            span = 32'd1 << (first + j);
            p    = p & ((p << span) | ~({WIDTH{1'b1}} << span));
         end
      end
      return p;
   endfunction

   logic adv_c;

   // Operand preparation: invert B for subtract and fold carry-in into bit 0 generate.
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] prep_p;
   logic [WIDTH-1:0] prep_g;

   always_comb begin : prep
      b_eff     = in_sub ? ~in_b : in_b;
      c0        = in_sub | in_cin;
      prep_p    = in_a ^ b_eff;
      prep_g    = in_a & b_eff;
      prep_g[0] = prep_g[0] | (prep_p[0] & c0);
   end

   // Per-stage pipeline registers: prefix (G,P), original p for the sum, c0, operand MSBs.
   logic [WIDTH-1:0] g_q  [NSTG];
   logic [WIDTH-1:0] g_d  [NSTG];
   logic [WIDTH-1:0] p_q  [NSTG];
   logic [WIDTH-1:0] p_d  [NSTG];
   logic [WIDTH-1:0] po_q [NSTG];
   logic [WIDTH-1:0] po_d [NSTG];
   logic             c0_q [NSTG];
   logic             c0_d [NSTG];
   logic             am_q [NSTG];
   logic             am_d [NSTG];
   logic             bm_q [NSTG];
   logic             bm_d [NSTG];
   logic             vld_q[NSTG];
   logic             vld_d[NSTG];

   logic [WIDTH-1:0] src_g [NSTG];
   logic [WIDTH-1:0] src_p [NSTG];
   logic [WIDTH-1:0] src_po[NSTG];
   logic             src_c0[NSTG];
   logic             src_am[NSTG];
   logic             src_bm[NSTG];
   logic             src_v [NSTG];

   for (genvar s = 0; s < NSTG; s++) begin : g_stage
      if (s == 0) begin : g_src_in
         assign src_g[s]  = prep_g;
         assign src_p[s]  = prep_p;
         assign src_po[s] = prep_p;
         assign src_c0[s] = c0;
         assign src_am[s] = in_a[WIDTH-1];
         assign src_bm[s] = b_eff[WIDTH-1];
         assign src_v[s]  = in_valid;
      end else begin : g_src_prev
         assign src_g[s]  = ks_g(g_q[s-1], p_q[s-1], (s - 1) * REG_EVERY);
         assign src_p[s]  = ks_p(p_q[s-1], (s - 1) * REG_EVERY);
         assign src_po[s] = po_q[s-1];
         assign src_c0[s] = c0_q[s-1];
         assign src_am[s] = am_q[s-1];
         assign src_bm[s] = bm_q[s-1];
         assign src_v[s]  = vld_q[s-1];
      end

      // Whole pipeline advances together; bubbles travel with valid=0.
      always_comb begin : stage_next
         g_d[s]   = g_q[s];
         p_d[s]   = p_q[s];
         po_d[s]  = po_q[s];
         c0_d[s]  = c0_q[s];
         am_d[s]  = am_q[s];
         bm_d[s]  = bm_q[s];
         vld_d[s] = vld_q[s];
         if (adv_c) begin
            g_d[s]   = src_g[s];
            p_d[s]   = src_p[s];
            po_d[s]  = src_po[s];
            c0_d[s]  = src_c0[s];
            am_d[s]  = src_am[s];
            bm_d[s]  = src_bm[s];
            vld_d[s] = src_v[s];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin : stage_reg
         if (!rst_n) begin
            g_q[s]   <= '0;
            p_q[s]   <= '0;
            po_q[s]  <= '0;
            c0_q[s]  <= 1'b0;
            am_q[s]  <= 1'b0;
            bm_q[s]  <= 1'b0;
            vld_q[s] <= 1'b0;
         end else begin
            g_q[s]   <= g_d[s];
            p_q[s]   <= p_d[s];
            po_q[s]  <= po_d[s];
            c0_q[s]  <= c0_d[s];
            am_q[s]  <= am_d[s];
            bm_q[s]  <= bm_d[s];
            vld_q[s] <= vld_d[s];
         end
      end
   end

   // Final prefix group feeds the output register directly.
   logic [WIDTH-1:0] fin_g;
   assign fin_g = ks_g(g_q[LAST], p_q[LAST], LAST * REG_EVERY);

   logic [WIDTH-1:0] sum_c;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic             out_cout_q, out_cout_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_zero_q, out_zero_d;

   assign adv_c    = ~out_valid_q | out_ready;
   assign in_ready = adv_c;

   // Sum uses carry into bit i = G[i-1], with c0 into bit 0.
   always_comb begin : out_next
      sum_c       = po_q[LAST] ^ {fin_g[WIDTH-2:0], c0_q[LAST]};
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_ovf_d   = out_ovf_q;
      out_zero_d  = out_zero_q;
      if (adv_c) begin
         out_valid_d = vld_q[LAST];
         out_sum_d   = sum_c;
         out_cout_d  = fin_g[WIDTH-1];
         out_ovf_d   = (am_q[LAST] == bm_q[LAST]) & (sum_c[WIDTH-1] != am_q[LAST]);
         out_zero_d  = (sum_c == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : out_reg
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_zero_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe (WIDTH=16, REG_EVERY=2, latency 3): directed corner cases,
// full-rate random stream with a stall window, mid-flight reset and random handshakes,
// all checked against an integer-arithmetic reference kept in an expected-result queue.
module tb_ks_adder_pipe;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         out_zero;

   int checks = 0;
   int errors = 0;

   logic [W+2:0] exp_q[$];

   logic         s_in_ready;
   logic         s_out_valid;
   logic [W-1:0] s_sum;
   logic         s_cout;
   logic         s_ovf;
   logic         s_zero;

   ks_adder_pipe #(.WIDTH(W), .REG_EVERY(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer add/subtract; packed as {ovf, zero, cout, sum}.
   function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      int          sa;
      int          sb;
      int          ua;
      int          ub;
      int          full;
      int          sr;
      logic        cout;
      logic        ovf;
      logic [W-1:0] sum;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      if (sub) begin
         full = ua - ub;
         cout = (ua >= ub);
         sr   = sa - sb;
      end else begin
         full = ua + ub + int'(cin);
         cout = (full > 65535);
         sr   = sa + sb + int'(cin);
      end
      sum = W'(full);
      ovf = (sr > 32767) || (sr < -32768);
      return {ovf, (sum == '0), cout, sum};
   endfunction

   function automatic logic [W-1:0] rop();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = 16'h0000;
         1:       v = 16'hFFFF;
         2:       v = 16'h8000;
         3:       v = 16'h7FFF;
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      in_a   = a;
      in_b   = b;
      in_cin = cin;
      in_sub = sub;
   endtask

   // One clock: sample at negedge, score handshakes, return 1 ns after the rising edge.
   task automatic tick();
      logic [W+2:0] e;
      @(negedge clk);
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_sum       = out_sum;
      s_cout      = out_cout;
      s_ovf       = out_ovf;
      s_zero      = out_zero;
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            chk("result", 32'({out_ovf, out_zero, out_cout, out_sum}), 32'(e));
         end
      end
      if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'(0));
   endtask

   logic [W-1:0] held_sum;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(16'h0, 16'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_sum", 32'(out_sum), 32'(0));
      chk("rst_out_cout", 32'(out_cout), 32'(0));
      chk("rst_out_ovf", 32'(out_ovf), 32'(0));
      chk("rst_out_zero", 32'(out_zero), 32'(0));
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(1));

      // FFFF + 0001: wraps to zero with carry-out, visible exactly 3 cycles after accept.
      drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      chk("t1_accept", 32'(s_in_ready), 32'(1));
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("t1_latency_valid", 32'(s_out_valid), 32'(c == 3));
         if (c == 3) begin
            chk("t1_sum", 32'(s_sum), 32'h0000);
            chk("t1_cout", 32'(s_cout), 32'(1));
            chk("t1_zero", 32'(s_zero), 32'(1));
            chk("t1_ovf", 32'(s_ovf), 32'(0));
         end
      end

      // Back-to-back subtracts: 8000-0001 overflows, 0003-0005 borrows.
      in_valid = 1'b1;
      drive(16'h8000, 16'h0001, 1'b0, 1'b1);
      tick();
      drive(16'h0003, 16'h0005, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("t2a_valid", 32'(s_out_valid), 32'(1));
      chk("t2a_sum", 32'(s_sum), 32'h7FFF);
      chk("t2a_cout", 32'(s_cout), 32'(1));
      chk("t2a_ovf", 32'(s_ovf), 32'(1));
      chk("t2a_zero", 32'(s_zero), 32'(0));
      tick();
      chk("t2b_valid", 32'(s_out_valid), 32'(1));
      chk("t2b_sum", 32'(s_sum), 32'hFFFE);
      chk("t2b_cout", 32'(s_cout), 32'(0));
      chk("t2b_ovf", 32'(s_ovf), 32'(0));
      drain(10);

      // Full-rate random stream with a 5-cycle output stall in the middle.
      in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         drive(rop(), rop(), 1'($urandom), 1'($urandom));
         out_ready = !(i >= 500 && i < 505);
         tick();
         if (i >= 3) chk("stream_throughput", 32'(s_out_valid), 32'(1));
         if (i == 500) held_sum = s_sum;
         if (i >= 500 && i < 505) begin
            chk("stall_in_ready", 32'(s_in_ready), 32'(0));
            chk("stall_sum_stable", 32'(s_sum), 32'(held_sum));
         end
      end
      drain(10);

      // Reset with three beats in flight (one already presented at the output).
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(rop(), rop(), 1'($urandom), 1'($urandom));
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("pre_reset_valid", 32'(s_out_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("reset_async_valid", 32'(out_valid), 32'(0));
      exp_q.delete();
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_reset_no_stale", 32'(s_out_valid), 32'(0));
      end
      drive(16'h1234, 16'h4321, 1'b1, 1'b0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      drain(10);

      // Random valid/ready handshakes.
      for (int i = 0; i < 3000; i++) begin
         drive(rop(), rop(), 1'($urandom), 1'($urandom));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
